// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size codes, state
// encoding and the big-endian lane extract/merge helpers.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_RMW_WR
    } mau_state_t;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  offset,
        input logic [1:0]  size,
        input logic        sign_ext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offset)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = offset[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: r = {{24{sign_ext & b[7]}}, b};
            SZ_HALF: r = {{16{sign_ext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of an existing word with right-justified store data.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [1:0]  offset,
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    r[31:24] = wdata[7:0];
                    2'd1:    r[23:16] = wdata[7:0];
                    2'd2:    r[15:8]  = wdata[7:0];
                    default: r[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1])
                    r[15:0] = wdata[15:0];
                else
                    r[31:16] = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mau_lane_ext.sv
// Combinational load-lane extraction with sign/zero extension.
module mau_lane_ext
    import mau_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    assign data = lane_extract(word, offset, size, sign_ext);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a word-wide big-endian data memory.
// Optional misalignment counter output enabled by defining MAU_ERR_CNT_EN.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DM_AW     = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] dm_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wrdata,
    output logic        dm_memwrite,
    output logic        dm_memread,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
`ifdef MAU_ERR_CNT_EN
    output logic        align_err,
    output logic [ERR_CNT_W-1:0] align_err_cnt
`else
    output logic        align_err
`endif
);

    if (ERR_CNT_W < 1 || DM_AW < 3 || DM_AW > 31) begin : g_bad_params
        $error("mem_access_unit: illegal DM_AW or ERR_CNT_W");
    end

    mau_state_t         state_reg, state_next;
    logic [31:0]        merge_reg, merge_next;
    logic [DM_AW-3:0]   addr_reg, addr_next;
    logic [31:0]        load_data_reg;
    logic               load_valid_reg;
    logic               align_err_reg;

    logic [31:0]        ext_data;
    logic               misaligned;
    logic               sub_word;
    logic               load_acc;
    logic               err_acc;
    logic [31:0]        addr_int;
    logic [31:0]        wrdata_int;
    logic               memwrite_int;
    logic               memread_int;
    logic               stall_int;

    wire unused_addr_hi = ^req_addr[31:DM_AW];

    // Size 11 shares the word path, so size[1] alone selects word handling.
    assign sub_word   = ~req_size[1];
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));

    mau_lane_ext u_lane_ext (
        .word     (dm_rdata),
        .offset   (req_addr[1:0]),
        .size     (req_size),
        .sign_ext (req_signed),
        .data     (ext_data)
    );

    always_comb begin
        state_next   = state_reg;
        merge_next   = merge_reg;
        addr_next    = addr_reg;
        addr_int     = '0;
        wrdata_int   = '0;
        memwrite_int = 1'b0;
        memread_int  = 1'b0;
        stall_int    = 1'b0;
        load_acc     = 1'b0;
        err_acc      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_int = {{(32-DM_AW){1'b0}}, req_addr[DM_AW-1:2], 2'b00};
                    if (misaligned) begin
                        err_acc = 1'b1;
                    end else if (!req_write) begin
                        memread_int = 1'b1;
                        load_acc    = 1'b1;
                    end else if (!sub_word) begin
                        memwrite_int = 1'b1;
                        wrdata_int   = req_wdata;
                    end else begin
                        memread_int = 1'b1;
                        stall_int   = 1'b1;
                        merge_next  = lane_merge(dm_rdata, req_addr[1:0], req_size, req_wdata);
                        addr_next   = req_addr[DM_AW-1:2];
                        state_next  = ST_RMW_WR;
                    end
                end
            end
            ST_RMW_WR: begin
                addr_int   = {{(32-DM_AW){1'b0}}, addr_reg, 2'b00};
                state_next = ST_IDLE;
                // A dropped req_valid here is a pipeline flush: abandon the write.
                if (req_valid) begin
                    memwrite_int = 1'b1;
                    wrdata_int   = merge_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory-facing strobes are forced low during reset so nothing is written.
    assign dm_addr     = rst_n ? addr_int : '0;
    assign dm_wrdata   = rst_n ? wrdata_int : '0;
    assign dm_memwrite = rst_n & memwrite_int;
    assign dm_memread  = rst_n & memread_int;
    assign stall       = rst_n & stall_int;
    assign load_data   = load_data_reg;
    assign load_valid  = load_valid_reg;
    assign align_err   = align_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            merge_reg      <= '0;
            addr_reg       <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            align_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            merge_reg      <= merge_next;
            addr_reg       <= addr_next;
            load_valid_reg <= load_acc;
            align_err_reg  <= err_acc;
            if (load_acc)
                load_data_reg <= ext_data;
        end
    end

`ifdef MAU_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_reg <= '0;
        else if (align_err_reg && (err_cnt_reg != {ERR_CNT_W{1'b1}}))
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
    end

    assign align_err_cnt = err_cnt_reg;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store front end sitting directly upstream of the word-wide big-endian data memory. It accepts one load/store request per cycle from the EX/MEM register and drives the memory's addr/wrdata/memwrite/memread pins. Byte and halfword stores are turned into a two-cycle read-modify-write, with a stall back to the pipeline. Loaded bytes and halfwords are extracted, sign- or zero-extended, and registered for the MEM/WB stage.

Parameters:
DM_AW, 8, address bits the data memory decodes; dm_addr[31:DM_AW] are driven as 0.
ERR_CNT_W, 16, width of the misalignment counter (optional feature only).

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present; held stable by the pipeline while stall=1.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word; 11 is reserved and treated as word.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
dm_rdata  in  32  combinational read data from the data memory.
dm_addr  out  32  word-aligned address to the data memory (bits [1:0] = 00).
dm_wrdata  out  32  full word to write.
dm_memwrite  out  1  write strobe, sampled by the memory at posedge.
dm_memread  out  1  read qualifier.
stall  out  1  freeze upstream pipeline registers.
load_data  out  32  extended load result, registered.
load_valid  out  1  one-cycle pulse, the cycle after a load is accepted.
align_err  out  1  one-cycle pulse, the cycle after a misaligned request.

Behaviour:
- Reset: state=IDLE, merge buffer=0, load_data=0, load_valid=0, align_err=0. Combinational outputs drive 0 while rst_n=0, so no write can occur during reset.
- Byte lane order (big-endian): offset 0 is bits [31:24], offset 3 is bits [7:0]. Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- Misaligned request: half with addr[0]=1, or word with addr[1:0]!=00.
  - No memory access; dm_memwrite=0 and dm_memread=0.
  - align_err pulses the next cycle; load_valid stays 0; no stall.
- States: IDLE, RMW_WR.
- IDLE, aligned load:
  - dm_memread=1 and dm_addr driven combinationally.
  - At posedge, the extracted, extended value is registered into load_data and load_valid=1 the next cycle. Latency is 1; no stall.
- IDLE, word store: dm_memwrite=1 and dm_wrdata=req_wdata in the same cycle; single cycle, no stall.
- IDLE, byte/half store (read phase):
  - dm_memread=1, stall=1.
  - At posedge, dm_rdata is latched into the merge buffer with the target lane(s) replaced by req_wdata[7:0] or req_wdata[15:0]. Next state is RMW_WR.
- RMW_WR (write phase):
  - dm_memwrite=1, dm_wrdata=merge buffer, dm_addr from the held req_addr, stall=0.
  - Next state is IDLE.
- req_valid=0 in RMW_WR (flush): abort to IDLE with dm_memwrite=0 and no write.
- Reset asserted mid-RMW: the pending write is dropped and the state goes to IDLE.
- Back-to-back requests: the held store is executed exactly once. The request after an RMW is sampled in IDLE on the following cycle.
- Address wrap: addr bits above DM_AW are ignored; no range error is flagged.

Optional Feature:
MAU_ERR_CNT_EN
- Defined:
  - Adds output align_err_cnt [ERR_CNT_W-1:0], reset to 0.
  - Increments on each align_err pulse and saturates at all-ones.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mau_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum {ST_IDLE, ST_RMW_WR};
  - the lane-extract and lane-merge functions.
- One natural sub-module, mau_lane_ext: combinational byte/half extraction plus sign/zero extension, given (word, offset, size, signed).

Test Plan:
- Word store 0xDEADBEEF at 0x10, then signed byte load at 0x11 -> single-cycle write with no stall; load_data=0xFFFFFFAD with load_valid one cycle later.
- Memory word 0x11223344 at 0x20; sb 0xAA at 0x22 -> stall high for 1 cycle; write 0x1122AA44 in the RMW_WR cycle; memory holds 0x1122AA44.
- Memory word 0x11223344 at 0x20; unsigned half load at 0x20 -> load_data=0x00001122. Signed half load at 0x22 of 0x8001 -> 0xFFFF8001.
- lw at 0x13 and sh at 0x05 -> no dm_memwrite or dm_memread, align_err pulse each time, load_valid=0; with MAU_ERR_CNT_EN defined, the count is 2.
- sb at 0x30, then deassert req_valid during RMW_WR -> no write; memory at 0x30 unchanged.
- Assert rst_n=0 in the cycle after an sh read phase -> no write occurs; outputs are 0 and the state is IDLE after release.
